// File: rtl/cpu_fetch_pkg.sv
// Shared types and constants for the instruction prefetch unit.
//   fetch_state_t   : fetch sequencer states
//   FETCH_MASK_WORD : byte mask driven on every (word) read
//   fetch_entry_t   : queue entry layout {data, pc, misaligned} for the default 32-bit PC
//   fetch_entry_width(): packed entry width for an arbitrary PC width
package cpu_fetch_pkg;

  typedef enum logic [1:0] {
    FETCH_IDLE,
    FETCH_WAIT,
    FETCH_DISCARD,
    FETCH_HALT
  } fetch_state_t;

  localparam logic [3:0] FETCH_MASK_WORD = 4'b1111;

  localparam int unsigned FETCH_PC_WIDTH = 32;

  typedef struct packed {
    logic [31:0]               data;
    logic [FETCH_PC_WIDTH-1:0] pc;
    logic                      misaligned;
  } fetch_entry_t;

  // The queue stores entries as flat vectors so the PC width can follow ADDR_WIDTH.
  function automatic int unsigned fetch_entry_width(input int unsigned addr_width);
    return 32 + addr_width + 1;
  endfunction

endpackage

// File: rtl/cpu_fetch_fifo.sv
// Synchronous FIFO holding fetched instruction entries.
// Ports:
//   clk, rst     : clock, asynchronous active-low reset
//   push         : write push_data at the tail
//   pop          : drop the head entry (ignored when empty)
//   clear        : empty the queue; wins over push and pop
//   push_data    : entry to write
//   head         : head entry, all zeros when empty
//   count        : number of valid entries (0..DEPTH)
module cpu_fetch_fifo
  import cpu_fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = fetch_entry_width(32)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     clear,
  input  logic [WIDTH-1:0]         push_data,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_COUNT = (PW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [PW:0]      count_q;
  logic             do_push, do_pop;

  assign do_pop  = pop && (count_q != '0) && !clear;
  // A push into a full queue is only legal when the head leaves on the same edge.
  assign do_push = push && ((count_q != FULL_COUNT) || do_pop) && !clear;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (clear) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: head is masked to zero while the queue is empty.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

  assign head  = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
  assign count = count_q;

endmodule

// File: rtl/cpu_fetch_unit.sv
// Instruction prefetch unit: runs word reads on the ma_* bus ahead of execution and
// queues {data, pc, misaligned} entries for the execute stage.
// Optional build macro: CPU_FETCH_STATS_EN adds stat_fetched / stat_discarded counters.
// Ports:
//   clk, rst           : clock, asynchronous active-low reset
//   redirect           : flush queue, restart fetch at redirect_addr
//   inst_valid/ready   : head handshake; inst_data, inst_pc, inst_misaligned = head entry
//   ma_addr, ma_rd_req : read address and level request, held until ma_done
//   ma_data_mask       : constant full-word mask
//   ma_data_in, ma_done: read data and completion strobe
module cpu_fetch_unit
  import cpu_fetch_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH      = 32,
  parameter int unsigned           DEPTH           = 4,
  parameter logic [ADDR_WIDTH-1:0] EXEC_START_ADDR = ADDR_WIDTH'(32'h4000_0000)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  redirect,
  input  logic [ADDR_WIDTH-1:0] redirect_addr,
  output logic                  inst_valid,
  input  logic                  inst_ready,
  output logic [31:0]           inst_data,
  output logic [ADDR_WIDTH-1:0] inst_pc,
  output logic                  inst_misaligned,
  output logic [ADDR_WIDTH-1:0] ma_addr,
  output logic                  ma_rd_req,
  output logic [3:0]            ma_data_mask,
  input  logic [31:0]           ma_data_in,
  input  logic                  ma_done
`ifdef CPU_FETCH_STATS_EN
  ,
  output logic [31:0]           stat_fetched,
  output logic [31:0]           stat_discarded
`endif
);

  localparam int unsigned EW = fetch_entry_width(ADDR_WIDTH);
  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  fetch_state_t          state_q, state_d;
  logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  req_q, req_d;

  logic          push, pop_fire, dropped, has_free;
  logic [EW-1:0] push_data, head;
  logic [CW-1:0] count, occ_after;

  // Redirect wins over a pop in the same cycle.
  assign pop_fire  = inst_valid && inst_ready && !redirect;
  assign occ_after = count - CW'(pop_fire);
  assign has_free  = occ_after < FULL_COUNT;

  cpu_fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .pop       (pop_fire),
    .clear     (redirect),
    .push_data (push_data),
    .head      (head),
    .count     (count)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= FETCH_IDLE;
      fetch_pc_q <= EXEC_START_ADDR;
      addr_q     <= EXEC_START_ADDR;
      req_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      addr_q     <= addr_d;
      req_q      <= req_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    addr_d     = addr_q;
    req_d      = req_q;
    push       = 1'b0;
    push_data  = {32'h0, fetch_pc_q, 1'b0};
    dropped    = 1'b0;

    unique case (state_q)
      FETCH_IDLE: begin
        // No request is outstanding here, so the free-slot check also reserves the slot
        // the next read will complete into.
        if (!redirect && has_free) begin
          if (fetch_pc_q[1:0] != 2'b00) begin
            push      = 1'b1;
            push_data = {32'h0, fetch_pc_q, 1'b1};
            state_d   = FETCH_HALT;
          end else begin
            req_d   = 1'b1;
            addr_d  = fetch_pc_q;
            state_d = FETCH_WAIT;
          end
        end
      end
      FETCH_WAIT: begin
        if (ma_done) begin
          req_d   = 1'b0;
          state_d = FETCH_IDLE;
          if (redirect) begin
            dropped = 1'b1;
          end else begin
            push       = 1'b1;
            push_data  = {ma_data_in, fetch_pc_q, 1'b0};
            fetch_pc_d = fetch_pc_q + ADDR_WIDTH'(4);
          end
        end else if (redirect) begin
          state_d = FETCH_DISCARD;
        end
      end
      FETCH_DISCARD: begin
        // Request stays up with a stable address until the bus finishes; data is dropped.
        if (ma_done) begin
          req_d   = 1'b0;
          dropped = 1'b1;
          state_d = FETCH_IDLE;
        end
      end
      FETCH_HALT: begin
        if (redirect) state_d = FETCH_IDLE;
      end
      default: state_d = FETCH_IDLE;
    endcase

    if (redirect) fetch_pc_d = redirect_addr;
  end

  assign inst_valid      = (count != '0);
  assign inst_data       = head[EW-1 -: 32];
  assign inst_pc         = head[ADDR_WIDTH:1];
  assign inst_misaligned = head[0];
  assign ma_addr         = addr_q;
  assign ma_rd_req       = req_q;
  assign ma_data_mask    = FETCH_MASK_WORD;

`ifdef CPU_FETCH_STATS_EN
  logic [31:0] stat_fetched_q, stat_discarded_q;
  logic [31:0] flushed;

  // Entries still queued at a redirect are lost along with any dropped read.
  assign flushed = redirect ? 32'(count) : 32'h0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_fetched_q   <= '0;
      stat_discarded_q <= '0;
    end else begin
      stat_fetched_q   <= stat_fetched_q + 32'(push);
      stat_discarded_q <= stat_discarded_q + 32'(dropped) + flushed;
    end
  end

  assign stat_fetched   = stat_fetched_q;
  assign stat_discarded = stat_discarded_q;
`endif

endmodule

// File: tb/tb_cpu_fetch_unit.sv
// Directed bench for cpu_fetch_unit (DEPTH=4, ADDR_WIDTH=32) with a behavioural
// memory of programmable latency. Stat checks compile in under CPU_FETCH_STATS_EN.
module tb_cpu_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect;
  logic [31:0] redirect_addr;
  logic        inst_valid, inst_ready, inst_misaligned;
  logic [31:0] inst_data, inst_pc;
  logic [31:0] ma_addr;
  logic        ma_rd_req;
  logic [3:0]  ma_data_mask;
  logic [31:0] ma_data_in;
  logic        ma_done;
`ifdef CPU_FETCH_STATS_EN
  logic [31:0] stat_fetched, stat_discarded;
`endif

  int checks = 0;
  int errors = 0;
  int lat = 1;

  logic [31:0] req_q [$];
  logic [31:0] pop_pc_q [$];
  logic [31:0] pop_data_q [$];

  always #5 clk = ~clk;

  cpu_fetch_unit #(
    .ADDR_WIDTH      (32),
    .DEPTH           (4),
    .EXEC_START_ADDR (32'h4000_0000)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .redirect        (redirect),
    .redirect_addr   (redirect_addr),
    .inst_valid      (inst_valid),
    .inst_ready      (inst_ready),
    .inst_data       (inst_data),
    .inst_pc         (inst_pc),
    .inst_misaligned (inst_misaligned),
    .ma_addr         (ma_addr),
    .ma_rd_req       (ma_rd_req),
    .ma_data_mask    (ma_data_mask),
    .ma_data_in      (ma_data_in),
    .ma_done         (ma_done)
`ifdef CPU_FETCH_STATS_EN
    ,
    .stat_fetched    (stat_fetched),
    .stat_discarded  (stat_discarded)
`endif
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a >= 32'h4000_0000 && a < 32'h4000_0010) return 32'h0000_0013;
    return a ^ 32'h5A5A_0000;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // All directed stimulus and checks happen 2 time units after the rising edge.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_steps(input int n);
    repeat (n) step();
  endtask

  // Memory responder: ma_done pulses for one cycle after lat cycles of ma_rd_req.
  initial begin
    int cnt;
    cnt = 0;
    ma_done = 1'b0;
    ma_data_in = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst) begin
        ma_done = 1'b0;
        cnt = 0;
      end else if (ma_done) begin
        ma_done = 1'b0;
        ma_data_in = '0;
        cnt = 0;
      end else if (ma_rd_req) begin
        cnt++;
        if (cnt >= lat) begin
          ma_done = 1'b1;
          ma_data_in = mem_word(ma_addr);
        end
      end else begin
        cnt = 0;
      end
    end
  end

  // Monitor on the falling edge: request rising edges and accepted pops.
  initial begin
    logic prev_req;
    prev_req = 1'b0;
    forever begin
      @(negedge clk);
      if (ma_rd_req && !prev_req) req_q.push_back(ma_addr);
      if (inst_valid && inst_ready && !redirect) begin
        pop_pc_q.push_back(inst_pc);
        pop_data_q.push_back(inst_data);
      end
      prev_req = ma_rd_req;
    end
  end

  initial begin
    int req_len;
    logic [31:0] disc_addr;
    logic addr_bad;

    rst = 1'b0;
    redirect = 1'b0;
    redirect_addr = '0;
    inst_ready = 1'b0;
    wait_steps(2);

    // Reset state
    check("rst_valid", inst_valid, 0);
    check("rst_data", inst_data, 0);
    check("rst_pc", inst_pc, 0);
    check("rst_mis", inst_misaligned, 0);
    check("rst_req", ma_rd_req, 0);
    check("rst_addr", ma_addr, 32'h4000_0000);
    check("mask", ma_data_mask, 4'hF);

    // Streaming fetch with 1-cycle memory
    inst_ready = 1'b1;
    rst = 1'b1;
    step();
    check("first_req", ma_rd_req, 1);
    check("first_addr", ma_addr, 32'h4000_0000);
    for (int i = 0; i < 60 && pop_pc_q.size() < 4; i++) step();
    for (int i = 0; i < 4; i++) begin
      check($sformatf("stream_req%0d", i), req_q[i], 32'h4000_0000 + 32'(4 * i));
      check($sformatf("stream_pc%0d", i), pop_pc_q[i], 32'h4000_0000 + 32'(4 * i));
      check($sformatf("stream_data%0d", i), pop_data_q[i], 32'h0000_0013);
    end
    inst_ready = 1'b0;

    // Fill with no consumer: exactly DEPTH reads
    redirect = 1'b1;
    redirect_addr = 32'h4000_0000;
    step();
    redirect = 1'b0;
    req_q.delete();
    wait_steps(30);
    check("fill_nreq", req_q.size(), 4);
    check("fill_req3", req_q[3], 32'h4000_000C);
    check("fill_idle", ma_rd_req, 0);
    check("fill_valid", inst_valid, 1);
    check("fill_head", inst_pc, 32'h4000_0000);
    inst_ready = 1'b1;
    step();
    inst_ready = 1'b0;
    wait_steps(10);
    check("refill_nreq", req_q.size(), 5);
    check("refill_addr", req_q[4], 32'h4000_0010);
    check("refill_idle", ma_rd_req, 0);
    check("refill_head", inst_pc, 32'h4000_0004);

    // Redirect with a slow read outstanding
    lat = 3;
    inst_ready = 1'b1;
    for (int i = 0; i < 20 && !(ma_rd_req && !ma_done); i++) step();
    disc_addr = ma_addr;
    redirect = 1'b1;
    redirect_addr = 32'h4000_0100;
    inst_ready = 1'b0;
    step();
    redirect = 1'b0;
    req_len = req_q.size();
    pop_pc_q.delete();
    pop_data_q.delete();
    check("disc_held", ma_rd_req, 1);
    addr_bad = 1'b0;
    for (int i = 0; i < 20 && ma_rd_req; i++) begin
      if (ma_addr !== disc_addr) addr_bad = 1'b1;
      step();
    end
    check("disc_addr_stable", addr_bad, 0);
    for (int i = 0; i < 30 && !inst_valid; i++) step();
    check("redir_valid", inst_valid, 1);
    check("redir_pc", inst_pc, 32'h4000_0100);
    check("redir_data", inst_data, mem_word(32'h4000_0100));
    check("redir_req", req_q[req_len], 32'h4000_0100);

    // Misaligned redirect: marker entry, no bus access, halt
    lat = 1;
    wait_steps(20);
    redirect = 1'b1;
    redirect_addr = 32'h4000_0102;
    step();
    redirect = 1'b0;
    req_len = req_q.size();
    wait_steps(10);
    check("mis_noreq", req_q.size(), req_len);
    check("mis_req", ma_rd_req, 0);
    check("mis_valid", inst_valid, 1);
    check("mis_flag", inst_misaligned, 1);
    check("mis_pc", inst_pc, 32'h4000_0102);
    check("mis_data", inst_data, 0);
    inst_ready = 1'b1;
    step();
    inst_ready = 1'b0;
    wait_steps(5);
    check("halt_empty", inst_valid, 0);
    check("halt_noreq", req_q.size(), req_len);
    redirect = 1'b1;
    redirect_addr = 32'h4000_0200;
    step();
    redirect = 1'b0;
    req_len = req_q.size();
    for (int i = 0; i < 30 && !inst_valid; i++) step();
    check("resume_pc", inst_pc, 32'h4000_0200);
    check("resume_mis", inst_misaligned, 0);
    check("resume_req", req_q[req_len], 32'h4000_0200);

    // Asynchronous reset during a read with the queue otherwise full
    lat = 6;
    for (int i = 0; i < 80 && !(ma_rd_req && ma_addr == 32'h4000_020C); i++) step();
    check("pre_rst_req", ma_addr, 32'h4000_020C);
    check("pre_rst_valid", inst_valid, 1);
    rst = 1'b0;
    #1;
    check("arst_valid", inst_valid, 0);
    check("arst_req", ma_rd_req, 0);
    check("arst_addr", ma_addr, 32'h4000_0000);
    wait_steps(2);
    lat = 1;
    req_q.delete();
    rst = 1'b1;
    step();
    check("post_rst_req", ma_rd_req, 1);
    check("post_rst_addr", ma_addr, 32'h4000_0000);

    // Redirect together with a pop: queue empties, pop ignored
    wait_steps(30);
    check("full_nreq", req_q.size(), 4);
`ifdef CPU_FETCH_STATS_EN
    check("stat_fetched", stat_fetched, 4);
    check("stat_disc0", stat_discarded, 0);
`endif
    redirect = 1'b1;
    redirect_addr = 32'h4000_0300;
    inst_ready = 1'b1;
    step();
    redirect = 1'b0;
    inst_ready = 1'b0;
    check("rp_empty", inst_valid, 0);
`ifdef CPU_FETCH_STATS_EN
    check("stat_disc4", stat_discarded, 4);
`endif
    for (int i = 0; i < 30 && !inst_valid; i++) step();
    check("rp_pc", inst_pc, 32'h4000_0300);
`ifdef CPU_FETCH_STATS_EN
    check("stat_fetched5", stat_fetched, 5);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
